karatsuba_mul_seq: RTL and testbench

- Multi-cycle, handshaked Karatsuba multiplier for N_BITS x N_BITS operands, giving a 2*N_BITS product.
- Performs one Karatsuba split. The three partial products are computed in sequence on a single shared (H+1)-bit multiplier, then combined in a registered final step.
- Supports unsigned operation, and signed operation selected per transaction.
- Sits between a valid/ready producer and consumer in the arithmetic datapath. It is the area-reduced, registered successor to the purely combinational recursive multiplier.

---
 rtl/karatsuba_pkg.sv | 36 +++
 rtl/ks_half_mul.sv | 12 +
 rtl/karatsuba_mul_seq.sv | 153 +++++++++++++++
 tb/tb_karatsuba_mul_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared types and helpers for the sequential single-split Karatsuba multiplier.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPLo,
    StPHi,
    StPMid,
    StCombine,
    StDone
  } kmul_state_t;

  // Low-half width (a0/b0) for an n-bit operand.
  function automatic int unsigned kmul_h(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  // High-half width (a1/b1) for an n-bit operand.
  function automatic int unsigned kmul_l(input int unsigned n);
    return n / 2;
  endfunction

  // Magnitude of a width-bit value; the most-negative input maps to 2^(width-1), which still
  // fits in width unsigned bits.
  function automatic logic [63:0] kmul_abs(input logic [63:0] value, input logic sgn,
                                           input int unsigned width);
    logic [63:0] mask;
    logic [63:0] sh;
    logic        neg;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sh   = value >> (width - 1);
    neg  = sgn & sh[0];
    return neg ? ((~value + 64'd1) & mask) : (value & mask);
  endfunction

endpackage

// File: rtl/ks_half_mul.sv
// Combinational W x W unsigned multiplier shared by the three Karatsuba partial products.
module ks_half_mul #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = (2*W)'(a_i) * (2*W)'(b_i);

endmodule

// File: rtl/karatsuba_mul_seq.sv
// Handshaked multi-cycle Karatsuba multiplier: one split, three partial products computed in
// turn on a single shared (H+1)-bit multiplier, then a registered combine step.
module karatsuba_mul_seq
  import karatsuba_pkg::*;
#(
  parameter int unsigned N_BITS = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  input  logic                  sgn,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   c
);

  localparam int unsigned H  = kmul_h(N_BITS);
  localparam int unsigned L  = kmul_l(N_BITS);
  localparam int unsigned W  = H + 1;
  localparam int unsigned CW = 2 * N_BITS;

  if (N_BITS < 2 || N_BITS > 64) begin : gen_bad_width
    $error("karatsuba_mul_seq: N_BITS must be in 2..64");
  end

  kmul_state_t       state_q, state_d;
  logic [N_BITS-1:0] ma_q, ma_d;
  logic [N_BITS-1:0] mb_q, mb_d;
  logic              neg_q, neg_d;
  logic [2*H-1:0]    p0_q, p0_d;
  logic [2*L-1:0]    p2_q, p2_d;
  logic [2*W-1:0]    pm_q, pm_d;
  logic [CW-1:0]     c_q, c_d;

  logic [H-1:0]      a0, b0;
  logic [L-1:0]      a1, b1;
  logic [W-1:0]      sa, sb;
  logic [W-1:0]      mul_x, mul_y;
  logic [2*W-1:0]    mul_p;
  logic [2*W-1:0]    mid;
  logic [CW-1:0]     r;

  assign a0 = ma_q[H-1:0];
  assign b0 = mb_q[H-1:0];
  assign a1 = ma_q[N_BITS-1:H];
  assign b1 = mb_q[N_BITS-1:H];
  assign sa = W'(a0) + W'(a1);
  assign sb = W'(b0) + W'(b1);

  // Operand select for the shared multiplier follows the partial-product phase.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    case (state_q)
      StPLo: begin
        mul_x = W'(a0);
        mul_y = W'(b0);
      end
      StPHi: begin
        mul_x = W'(a1);
        mul_y = W'(b1);
      end
      StPMid: begin
        mul_x = sa;
        mul_y = sb;
      end
      default: ;
    endcase
  end

  ks_half_mul #(
    .W (W)
  ) u_half_mul (
    .a_i (mul_x),
    .b_i (mul_y),
    .p_o (mul_p)
  );

  // (a0+a1)(b0+b1) - a0b0 - a1b1 = a0b1 + a1b0, never negative.
  assign mid = pm_q - (2*W)'(p0_q) - (2*W)'(p2_q);
  assign r   = (CW'(p2_q) << (2*H)) + (CW'(mid) << H) + CW'(p0_q);

  always_comb begin
    state_d = state_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    p0_d    = p0_q;
    p2_d    = p2_q;
    pm_d    = pm_q;
    c_d     = c_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          ma_d    = N_BITS'(kmul_abs(64'(a), sgn, N_BITS));
          mb_d    = N_BITS'(kmul_abs(64'(b), sgn, N_BITS));
          neg_d   = sgn & (a[N_BITS-1] ^ b[N_BITS-1]);
          state_d = StPLo;
        end
      end
      StPLo: begin
        p0_d    = mul_p[2*H-1:0];
        state_d = StPHi;
      end
      StPHi: begin
        p2_d    = mul_p[2*L-1:0];
        state_d = StPMid;
      end
      StPMid: begin
        pm_d    = mul_p;
        state_d = StCombine;
      end
      StCombine: begin
        c_d     = neg_q ? (CW'(0) - r) : r;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      p0_q    <= '0;
      p2_q    <= '0;
      pm_q    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      p0_q    <= p0_d;
      p2_q    <= p2_d;
      pm_q    <= pm_d;
      c_q     <= c_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign c         = c_q;

endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Directed-vector bench for karatsuba_mul_seq at N_BITS=15 and N_BITS=2.
module tb_karatsuba_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv15, ir15, ov15, or15, sg15;
  logic [14:0] a15, b15;
  logic [29:0] c15;

  logic        iv2, ir2, ov2, or2, sg2;
  logic [1:0]  a2, b2;
  logic [3:0]  c2;

  int total = 0;
  int bad   = 0;

  karatsuba_mul_seq #(.N_BITS(15)) dut15 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv15),
    .in_ready  (ir15),
    .a         (a15),
    .b         (b15),
    .sgn       (sg15),
    .out_valid (ov15),
    .out_ready (or15),
    .c         (c15)
  );

  karatsuba_mul_seq #(.N_BITS(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .a         (a2),
    .b         (b2),
    .sgn       (sg2),
    .out_valid (ov2),
    .out_ready (or2),
    .c         (c2)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic run15(input string tag, input logic [14:0] av, input logic [14:0] bv,
                       input logic s, input logic [29:0] exp, input int hold);
    int   n;
    logic busy_ok;
    or15 = (hold == 0);
    n = 0;
    while (!ir15 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, "_rdy"}, 64'(ir15), 64'd1);
    a15  = av;
    b15  = bv;
    sg15 = s;
    iv15 = 1'b1;
    @(posedge clk);
    #1;
    iv15 = 1'b0;
    a15  = ~av;
    b15  = 15'($urandom);
    sg15 = ~s;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (ir15) busy_ok = 1'b0;
    end while (!ov15 && n < 20);
    check_val({tag, "_lat"}, 64'(n), 64'd5);
    check_val({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check_val({tag, "_c"}, 64'(c15), 64'(exp));
    if (hold > 0) begin
      // A competing request while the result is held must not be taken.
      a15  = 15'd1;
      b15  = 15'd1;
      iv15 = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val({tag, "_hold_ov"}, 64'(ov15), 64'd1);
        check_val({tag, "_hold_c"}, 64'(c15), 64'(exp));
        check_val({tag, "_hold_rdy"}, 64'(ir15), 64'd0);
      end
      or15 = 1'b1;
    end
    @(posedge clk);
    #1;
    iv15 = 1'b0;
  endtask

  task automatic run2(input string tag, input logic [1:0] av, input logic [1:0] bv,
                      input logic s, input logic [3:0] exp);
    int n;
    or2 = 1'b1;
    check_val({tag, "_rdy"}, 64'(ir2), 64'd1);
    a2  = av;
    b2  = bv;
    sg2 = s;
    iv2 = 1'b1;
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    a2  = ~av;
    b2  = ~bv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov2 && n < 20);
    check_val({tag, "_lat"}, 64'(n), 64'd5);
    check_val({tag, "_c"}, 64'(c2), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    logic seen;
    rst  = 1'b1;
    iv15 = 1'b0; or15 = 1'b1; sg15 = 1'b0; a15 = '0; b15 = '0;
    iv2  = 1'b0; or2  = 1'b1; sg2  = 1'b0; a2  = '0; b2  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_rdy15", 64'(ir15), 64'd1);
    check_val("rst_ov15", 64'(ov15), 64'd0);
    check_val("rst_c15", 64'(c15), 64'd0);
    check_val("rst_rdy2", 64'(ir2), 64'd1);
    check_val("rst_ov2", 64'(ov2), 64'd0);
    @(posedge clk);
    #1;

    run15("max",      15'h7FFF, 15'h7FFF, 1'b0, 30'd1073676289, 0);
    run15("mneg3",    15'h4000, 15'd3,    1'b1, 30'h3FFF4000,   0);
    run15("u4000x3",  15'h4000, 15'd3,    1'b0, 30'd49152,      0);
    run15("mnegsq",   15'h4000, 15'h4000, 1'b1, 30'd268435456,  0);
    run15("m1m1",     15'h7FFF, 15'h7FFF, 1'b1, 30'd1,          0);
    run15("zeroneg",  15'd0,    15'h7FFB, 1'b1, 30'd0,          0);
    run15("p5m7",     15'd5,    15'h7FF9, 1'b1, 30'h3FFFFFDD,   0);
    run15("hold",     15'd1234, 15'd5678, 1'b0, 30'd7006652,    10);
    run15("after",    15'd300,  15'd400,  1'b0, 30'd120000,     0);

    // Reset while the middle product is being formed.
    a15 = 15'd100; b15 = 15'd200; sg15 = 1'b0; iv15 = 1'b1;
    @(posedge clk);
    #1;
    iv15 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_rdy", 64'(ir15), 64'd1);
    check_val("midrst_ov", 64'(ov15), 64'd0);
    check_val("midrst_c", 64'(c15), 64'd0);
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ov15) seen = 1'b1;
    end
    check_val("midrst_no_ov", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    run15("post_rst", 15'd7, 15'd6, 1'b0, 30'd42, 0);

    run2("n2_33",   2'd3,  2'd3,  1'b0, 4'd9);
    run2("n2_20",   2'd2,  2'd0,  1'b0, 4'd0);
    run2("n2_mnsq", 2'b10, 2'b10, 1'b1, 4'd4);
    run2("n2_m1x1", 2'b11, 2'b01, 1'b1, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
